round_robin_packet_arbiter: RTL and testbench
=============================================

# round_robin_packet_arbiter

Shares one downstream beat channel between `N_REQ` requesters. Grants are round-robin and packet-locked. A granted requester keeps ownership until it transfers a beat flagged `req_last`, or until a hold watchdog expires. The block sits between the requester front-ends and the shared channel and drives the channel's select mux.

## Interface

- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `HOLD_LIMIT`, default 16: maximum locked cycles per grant; 0 disables the watchdog.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `req` input `N_REQ`: per-requester request / beat-valid.
- `req_last` input `N_REQ`: per-requester last-beat flag; sampled only for the current owner.
- `ready` input 1: downstream accepts a beat this cycle.
- `grants` output `N_REQ`: registered one-hot owner; all zero when idle.
- `grant_idx` output `$clog2(N_REQ)`: registered binary index of the owner; 0 when idle.
- `grant_valid` output 1: `|grants`.
- `fire` output 1: combinational; `grant_valid & req[grant_idx] & ready`.
- `timeout` output 1: registered one-cycle pulse on watchdog release.

## Operation

- Internal state:
  - `state` is IDLE or LOCKED.
  - `ptr` is the next-priority index.
  - `hold_cnt` is width `$clog2(HOLD_LIMIT+1)`, minimum 1.
- Reset (`rst` = 0 at an edge) forces:
  - `state` = IDLE, `ptr` = 0, `hold_cnt` = 0.
  - `grants` = 0, `grant_idx` = 0, `timeout` = 0.
- Reset overrides everything, including mid-packet. No release side effects occur and `timeout` is not pulsed.
- IDLE:
  - If `req` ≠ 0, pick the winner by scanning `ptr`, `ptr+1`, … mod `N_REQ`; the first asserted `req` wins.
  - The winner is registered: next cycle `grants` = onehot(winner), `grant_idx` = winner, `state` = LOCKED, `hold_cnt` = 0.
  - If `req` = 0, stay IDLE.
- LOCKED:
  - Other requests are ignored.
  - The owner may drop `req` mid-packet; the lock holds and `fire` is 0 that cycle.
  - Normal release: `fire` and `req_last[grant_idx]` are both 1. Next cycle `state` = IDLE, `grants` = 0, `ptr` = (owner+1) mod `N_REQ`.
  - Watchdog release: `HOLD_LIMIT` ≠ 0, `hold_cnt` = `HOLD_LIMIT`−1, and no normal release this cycle. Next cycle `state` = IDLE, `grants` = 0, `ptr` = (owner+1) mod `N_REQ`, `timeout` = 1 for exactly that cycle.
  - Otherwise `hold_cnt` increments, saturating at `HOLD_LIMIT`−1.
- Normal release and watchdog expiry in the same cycle: normal release wins and `timeout` stays 0.
- `ptr` changes only on release, never on grant.
- Pointer arithmetic wraps modulo `N_REQ` (also for non-power-of-two `N_REQ`).
- `req_last` of non-owners is ignored, as is `req_last` of the owner when `fire` = 0.

## Timing

- Grant latency: one cycle from `req` seen in IDLE to `grants` asserted.
- Minimum packet period is 2 cycles. Release always returns through one IDLE cycle, in which the next arbitration happens, so `grants` is 0 for exactly one cycle between back-to-back packets.
- Lock duration under watchdog is exactly `HOLD_LIMIT` cycles of `grant_valid` = 1.
- `grants`, `grant_idx`, `grant_valid` and `timeout` are glitch-free registered outputs; `fire` is combinational from `req` and `ready`.
- No combinational path exists from `req` or `ready` to `grants`.

## Test plan

All scenarios use `N_REQ` = 4 and `HOLD_LIMIT` = 8.

- **Reset:** `rst` = 0 for 2 cycles with `req` = 1111 → `grants` = 0000 and `timeout` = 0 throughout; one cycle after `rst` = 1, `grants` = 0001.
- **Rotation:** `req` = 1111, `req_last` = 1111, `ready` = 1 held constant → `grants` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- **Lock hold:** req1 runs a 3-beat packet with `ready` = 1, 0, 1, 1 and req0 asserted throughout → `grants` stays 0010 for 4 cycles, `fire` = 1, 0, 1, 1, then 0000; next grant is 0001 with `ptr` = 2.
- **Watchdog:** req2 granted, never asserts `req_last` → `grants` = 0100 for exactly 8 cycles, then 0000 with `timeout` = 1 for one cycle; with `req` = 1111 the next grant is 1000.
- **Collision:** owner's last beat fires in the 8th locked cycle → release with `timeout` = 0.
- **Sparse and mid-packet reset:** from `ptr` = 0, `req` = 1010 → grant 0010, then after release grant 1000. `rst` = 0 while 1000 is locked → next cycle `grants` = 0000 and `ptr` = 0, so `req` = 1111 then yields 0001.

Source files
------------

// File: rtl/round_robin_packet_arbiter.sv
// round_robin_packet_arbiter: round-robin, packet-locked owner select with hold watchdog
module round_robin_packet_arbiter #(
  parameter int N_REQ = 4,
  parameter int HOLD_LIMIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_last,
  input  logic                     ready,
  output logic [N_REQ-1:0]         grants,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_valid,
  output logic                     fire,
  output logic                     timeout
);
  localparam int IW = $clog2(N_REQ);
  localparam int HW = HOLD_LIMIT > 0 ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [HW-1:0] HLIM = HW'(HOLD_LIMIT > 0 ? HOLD_LIMIT - 1 : 0);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0]    state;
  logic [IW-1:0] ptr, win, nxt;
  logic [IW:0]   sum, wrap;
  logic [HW-1:0] hold_cnt;
  logic          rel, wd;
  assign grant_valid = |grants;
  assign fire = grant_valid & req[grant_idx] & ready;
  assign rel = fire & req_last[grant_idx];
  assign wd = (HOLD_LIMIT != 0) && (hold_cnt == HLIM);
  assign nxt = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  always_comb begin
    win = ptr;
    sum = '0;
    wrap = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      wrap = (sum >= (IW+1)'(N_REQ)) ? sum - (IW+1)'(N_REQ) : sum;
      if (req[wrap[IW-1:0]]) win = wrap[IW-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      grants <= '0;
      grant_idx <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          state <= LOCKED;
          grants <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
          grant_idx <= win;
          hold_cnt <= '0;
        end
      end else if (rel || wd) begin
        state <= IDLE;
        grants <= '0;
        grant_idx <= '0;
        ptr <= nxt;
        timeout <= !rel;
      end else if (hold_cnt != HLIM) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_round_robin_packet_arbiter.sv
// tb_round_robin_packet_arbiter: table-driven scenarios with a grants/timeout scoreboard
module tb_round_robin_packet_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] req = '0, req_last = '0;
  logic ready = 1'b0;
  logic [3:0] grants;
  logic [1:0] grant_idx;
  logic grant_valid, fire, timeout;
  int tests = 0, fails = 0;
  logic [4:0] q[$];
  always #5 clk = ~clk;
  round_robin_packet_arbiter #(.N_REQ(4), .HOLD_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .ready(ready),
    .grants(grants), .grant_idx(grant_idx), .grant_valid(grant_valid),
    .fire(fire), .timeout(timeout)
  );
  function automatic logic [1:0] oh2i(input logic [3:0] g);
    return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    logic [15:0] tab [3] = '{
      16'b0_1111_0000_0_0_0000_0,
      16'b0_1111_0000_0_0_0000_0,
      16'b1_1111_0000_0_0_0001_0
    };
    foreach (tab[i]) q.push_back(tab[i][4:0]);
    foreach (tab[i]) begin
      logic [4:0] e;
      {rst, req, req_last, ready} = tab[i][15:6];
      #1;
      tests++;
      if (fire !== tab[i][5]) begin fails++; $display("FAIL reset[%0d] fire: got %b want %b", i, fire, tab[i][5]); end
      tick();
      e = q.pop_front();
      tests++;
      if ({grants, timeout, grant_valid, grant_idx} !== {e, |e[4:1], oh2i(e[4:1])}) begin
        fails++;
        $display("FAIL reset[%0d] outputs: grants=%b timeout=%b valid=%b idx=%0d want grants=%b timeout=%b", i, grants, timeout, grant_valid, grant_idx, e[4:1], e[0]);
      end
    end
  endtask
  task automatic test_rotation;
    logic [15:0] tab [10] = '{
      16'b0_0000_0000_0_0_0000_0,
      16'b1_1111_1111_1_0_0001_0,
      16'b1_1111_1111_1_1_0000_0,
      16'b1_1111_1111_1_0_0010_0,
      16'b1_1111_1111_1_1_0000_0,
      16'b1_1111_1111_1_0_0100_0,
      16'b1_1111_1111_1_1_0000_0,
      16'b1_1111_1111_1_0_1000_0,
      16'b1_1111_1111_1_1_0000_0,
      16'b1_1111_1111_1_0_0001_0
    };
    foreach (tab[i]) q.push_back(tab[i][4:0]);
    foreach (tab[i]) begin
      logic [4:0] e;
      {rst, req, req_last, ready} = tab[i][15:6];
      #1;
      tests++;
      if (fire !== tab[i][5]) begin fails++; $display("FAIL rotation[%0d] fire: got %b want %b", i, fire, tab[i][5]); end
      tick();
      e = q.pop_front();
      tests++;
      if ({grants, timeout, grant_valid, grant_idx} !== {e, |e[4:1], oh2i(e[4:1])}) begin
        fails++;
        $display("FAIL rotation[%0d] outputs: grants=%b timeout=%b valid=%b idx=%0d want grants=%b timeout=%b", i, grants, timeout, grant_valid, grant_idx, e[4:1], e[0]);
      end
    end
  endtask
  task automatic test_lock_hold;
    logic [15:0] tab [9] = '{
      16'b0_0000_0000_0_0_0000_0,
      16'b1_0001_0001_1_0_0001_0,
      16'b1_0001_0001_1_1_0000_0,
      16'b1_0011_0000_1_0_0010_0,
      16'b1_0011_0001_1_1_0010_0,
      16'b1_0011_0010_0_0_0010_0,
      16'b1_0011_0001_1_1_0010_0,
      16'b1_0011_0010_1_1_0000_0,
      16'b1_0011_0000_1_0_0001_0
    };
    foreach (tab[i]) q.push_back(tab[i][4:0]);
    foreach (tab[i]) begin
      logic [4:0] e;
      {rst, req, req_last, ready} = tab[i][15:6];
      #1;
      tests++;
      if (fire !== tab[i][5]) begin fails++; $display("FAIL lock_hold[%0d] fire: got %b want %b", i, fire, tab[i][5]); end
      tick();
      e = q.pop_front();
      tests++;
      if ({grants, timeout, grant_valid, grant_idx} !== {e, |e[4:1], oh2i(e[4:1])}) begin
        fails++;
        $display("FAIL lock_hold[%0d] outputs: grants=%b timeout=%b valid=%b idx=%0d want grants=%b timeout=%b", i, grants, timeout, grant_valid, grant_idx, e[4:1], e[0]);
      end
    end
  endtask
  task automatic test_watchdog;
    logic [15:0] tab [11] = '{
      16'b0_0000_0000_0_0_0000_0,
      16'b1_0100_0000_1_0_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0100_0,
      16'b1_1111_1011_1_1_0000_1,
      16'b1_1111_0000_1_0_1000_0
    };
    foreach (tab[i]) q.push_back(tab[i][4:0]);
    foreach (tab[i]) begin
      logic [4:0] e;
      {rst, req, req_last, ready} = tab[i][15:6];
      #1;
      tests++;
      if (fire !== tab[i][5]) begin fails++; $display("FAIL watchdog[%0d] fire: got %b want %b", i, fire, tab[i][5]); end
      tick();
      e = q.pop_front();
      tests++;
      if ({grants, timeout, grant_valid, grant_idx} !== {e, |e[4:1], oh2i(e[4:1])}) begin
        fails++;
        $display("FAIL watchdog[%0d] outputs: grants=%b timeout=%b valid=%b idx=%0d want grants=%b timeout=%b", i, grants, timeout, grant_valid, grant_idx, e[4:1], e[0]);
      end
    end
  endtask
  task automatic test_collision;
    logic [15:0] tab [11] = '{
      16'b0_0000_0000_0_0_0000_0,
      16'b1_0001_0000_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_0_0_0001_0,
      16'b1_0001_0001_1_1_0000_0,
      16'b1_0001_0000_0_0_0001_0
    };
    foreach (tab[i]) q.push_back(tab[i][4:0]);
    foreach (tab[i]) begin
      logic [4:0] e;
      {rst, req, req_last, ready} = tab[i][15:6];
      #1;
      tests++;
      if (fire !== tab[i][5]) begin fails++; $display("FAIL collision[%0d] fire: got %b want %b", i, fire, tab[i][5]); end
      tick();
      e = q.pop_front();
      tests++;
      if ({grants, timeout, grant_valid, grant_idx} !== {e, |e[4:1], oh2i(e[4:1])}) begin
        fails++;
        $display("FAIL collision[%0d] outputs: grants=%b timeout=%b valid=%b idx=%0d want grants=%b timeout=%b", i, grants, timeout, grant_valid, grant_idx, e[4:1], e[0]);
      end
    end
  endtask
  task automatic test_sparse_reset;
    logic [15:0] tab [6] = '{
      16'b0_0000_0000_0_0_0000_0,
      16'b1_1010_0000_1_0_0010_0,
      16'b1_1010_1010_1_1_0000_0,
      16'b1_1010_0000_1_0_1000_0,
      16'b0_1010_0000_1_1_0000_0,
      16'b1_1111_0000_1_0_0001_0
    };
    foreach (tab[i]) q.push_back(tab[i][4:0]);
    foreach (tab[i]) begin
      logic [4:0] e;
      {rst, req, req_last, ready} = tab[i][15:6];
      #1;
      tests++;
      if (fire !== tab[i][5]) begin fails++; $display("FAIL sparse_reset[%0d] fire: got %b want %b", i, fire, tab[i][5]); end
      tick();
      e = q.pop_front();
      tests++;
      if ({grants, timeout, grant_valid, grant_idx} !== {e, |e[4:1], oh2i(e[4:1])}) begin
        fails++;
        $display("FAIL sparse_reset[%0d] outputs: grants=%b timeout=%b valid=%b idx=%0d want grants=%b timeout=%b", i, grants, timeout, grant_valid, grant_idx, e[4:1], e[0]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_rotation();
    test_lock_hold();
    test_watchdog();
    test_collision();
    test_sparse_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
